wu_sched: RTL and testbench
===========================

WU_SCHED -- requirements
Module: wu_sched

Interface
REQ-001 Parameter dataWidth, default 32, element width in bits of the subtractor lanes this block sequences.
REQ-002 Parameter pactivation, default 16, number of parallel subtractor lanes (one row = pactivation elements).
REQ-003 Parameter ADDR_W, default 8, row address width of the weight/gradient buffers.
REQ-004 Parameter SUB_LAT, default 11, fixed latency in cycles of the floating-point subtract array, range 1..31.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  job request; sampled only in IDLE.
REQ-008 num_rows  input  ADDR_W+1  rows in job, sampled with start; 0 = empty job.
REQ-009 pause  input  1  issue hold from buffer arbiter; honoured only in ISSUE.
REQ-010 rd_en  output  1  read strobe to weight and gradient buffers (1-cycle read latency).
REQ-011 rd_addr  output  ADDR_W  row read address.
REQ-012 sub_en  output  1  drives the subtract array en/tvalid; rd_en delayed by exactly 1 cycle.
REQ-013 wr_en  output  1  write-back strobe for updated weights.
REQ-014 wr_addr  output  ADDR_W  write-back row address.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at job completion.
REQ-017 perf_cycles  output  16  job duration counter (see Configuration).

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN, DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-019 IDLE: start=1 with num_rows>0 -> ISSUE next cycle; start=1 with num_rows=0 -> DONE next cycle, no rd_en/wr_en issued.
REQ-020 start while not in IDLE SHALL be ignored; num_rows latched at accept, later changes ignored.
REQ-021 ISSUE: each cycle with pause=0 asserts rd_en with rd_addr = 0,1,...,num_rows-1 in order; pause=1 deasserts rd_en and holds rd_addr.
REQ-022 Row index counter ADDR_W+1 bits; num_rows = 2^ADDR_W issues addresses 0..2^ADDR_W-1 with no wrap to 0 before exit.
REQ-023 ISSUE -> DRAIN the cycle after the last row issues.
REQ-024 sub_en(t) = rd_en(t-1); wr_en(t) = sub_en(t-SUB_LAT); wr_addr(t) = rd_addr(t-1-SUB_LAT), carried by a valid/address shift pipeline.
REQ-025 Pipeline SHALL advance every cycle regardless of pause; bubbles propagate as wr_en=0.
REQ-026 DRAIN -> DONE the cycle after the last wr_en, i.e. when no valid remains in the pipeline.
REQ-027 Unpaused latency: start accepted cycle 0, rd_en cycles 1..N, wr_en cycles 2+SUB_LAT..N+1+SUB_LAT, done cycle N+2+SUB_LAT.
REQ-028 start asserted in the DONE cycle is ignored; a new job is accepted no earlier than the following IDLE cycle.

Reset
REQ-029 rst=0 asynchronously forces IDLE and clears the row counter, latched num_rows, pipeline valids/addresses and perf counter.
REQ-030 During reset all outputs SHALL be 0; in-flight writes of an interrupted job are discarded and never emitted after release.
REQ-031 First start accepted on the first rising edge with rst=1.

Configuration
REQ-032 Macro WU_SCHED_PERF_EN: when defined, perf_cycles clears at job accept, increments each cycle busy=1, saturates at 16'hFFFF, holds value in IDLE until next accept.
REQ-033 Without WU_SCHED_PERF_EN, perf_cycles SHALL be constant 0 and no counter logic is synthesised; all other behaviour identical.

Verification
REQ-034 N=4, SUB_LAT=11, pause=0, start at cycle 0 -> rd_addr 0..3 cycles 1-4, sub_en cycles 2-5, wr_addr 0..3 cycles 13-16, done cycle 17, perf_cycles=17 with macro.
REQ-035 N=3, pause=1 cycles 2-3 -> rd_en cycles 1,4,5 addr 0,1,2; wr_en cycles 13,16,17 addr 0,1,2; done cycle 18.
REQ-036 num_rows=0 -> no rd_en/wr_en, busy high cycle 1 only, done cycle 1.
REQ-037 ADDR_W=2, num_rows=4 -> addresses 0,1,2,3 once each, no wrap; second start during busy ignored.
REQ-038 rst low at cycle 6 of N=8 job -> all outputs 0 immediately, no wr_en after release; fresh N=2 job completes per REQ-027.

Source files
------------

// File: rtl/wu_sched_if.sv
// Signal bundle between the weight-update scheduler and the buffers, subtract array and job controller.
// The job controller side uses the master modport; the scheduler uses the slave modport.
interface wu_sched_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   num_rows;
  logic              pause;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              sub_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic [15:0]       perf_cycles;

  modport master (
    output start, num_rows, pause,
    input  rd_en, rd_addr, sub_en, wr_en, wr_addr, busy, done, perf_cycles
  );

  modport slave (
    input  start, num_rows, pause,
    output rd_en, rd_addr, sub_en, wr_en, wr_addr, busy, done, perf_cycles
  );
endinterface

// File: rtl/wu_sched.sv
// Weight-update scheduler: streams buffer rows into a fixed-latency subtract array and writes them back.
// Optional job-duration counter on perf_cycles is enabled by defining WU_SCHED_PERF_EN.
module wu_sched #(
  parameter int dataWidth   = 32,
  parameter int pactivation = 16,
  parameter int ADDR_W      = 8,
  parameter int SUB_LAT     = 11
) (
  input  logic      clk,
  input  logic      rst,
  wu_sched_if.slave bus
);

  if (SUB_LAT < 1 || SUB_LAT > 31 || dataWidth < 1 || pactivation < 1 ||
      $bits(bus.rd_addr) != ADDR_W) begin : g_param_check
    $error("wu_sched: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] ROW_ONE = 1;

  state_t             state;
  logic [ADDR_W:0]    rowCnt;
  logic [ADDR_W:0]    numRowsQ;
  logic               rdEn;
  logic               lastRow;
  logic               subEn;
  logic [ADDR_W-1:0]  subAddr;
  logic [SUB_LAT-1:0] vPipe;
  logic [ADDR_W-1:0]  aPipe [SUB_LAT];
  logic [SUB_LAT-1:0] vRemain;
  logic               pipeEmptyNext;

  assign rdEn    = (state == ISSUE) && !bus.pause;
  assign lastRow = (rowCnt == numRowsQ - ROW_ONE);

  // Valids still in flight after this edge: the top stage leaves as wr_en now.
  assign vRemain       = vPipe << 1;
  assign pipeEmptyNext = !subEn && (vRemain == '0);

  // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rowCnt   <= '0;
      numRowsQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            numRowsQ <= bus.num_rows;
            rowCnt   <= '0;
            state    <= (bus.num_rows == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.pause) begin
            rowCnt <= rowCnt + ROW_ONE;
            if (lastRow) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipeEmptyNext) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift pipeline mirrors the subtract array; it never stalls, so paused cycles travel as bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      subEn   <= 1'b0;
      subAddr <= '0;
      vPipe   <= '0;
      // NOTE: the address stages are reset too, so no stale address of an aborted job can reappear.
      for (int i = 0; i < SUB_LAT; i++) aPipe[i] <= '0;
    end else begin
      subEn    <= rdEn;
      subAddr  <= rowCnt[ADDR_W-1:0];
      vPipe    <= (vPipe << 1) | SUB_LAT'(subEn);
      aPipe[0] <= subAddr;
      for (int i = 1; i < SUB_LAT; i++) aPipe[i] <= aPipe[i-1];
    end
  end

  assign bus.rd_en   = rdEn;
  assign bus.rd_addr = rowCnt[ADDR_W-1:0];
  assign bus.sub_en  = subEn;
  assign bus.wr_en   = vPipe[SUB_LAT-1];
  assign bus.wr_addr = aPipe[SUB_LAT-1];
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

`ifdef WU_SCHED_PERF_EN
  logic [15:0] perfCnt;

  // Cleared on accept, counts busy cycles, saturates, and holds through IDLE for readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfCnt <= '0;
    end else if (state == IDLE) begin
      if (bus.start) perfCnt <= '0;
    end else if (perfCnt != 16'hFFFF) begin
      perfCnt <= perfCnt + 16'd1;
    end
  end

  assign bus.perf_cycles = perfCnt;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_wu_sched.sv
// Scoreboard bench for wu_sched: stimulus pushes expected rd/sub/wr/done events, a negedge monitor pops them.
// Two instances: ADDR_W=8/SUB_LAT=11 for the main jobs, ADDR_W=2/SUB_LAT=3 for the full-range job.
`timescale 1ns/1ps
module tb_wu_sched;
  localparam int AW0 = 8, LAT0 = 11;
  localparam int AW1 = 2, LAT1 = 3;

  typedef enum int {K_RD, K_SUB, K_WR, K_DONE} kind_t;
  typedef struct {
    int    dut;
    kind_t kind;
    int    cyc;
    int    addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lastDone [2];
  ev_t  expQ [$];

  wu_sched_if #(.ADDR_W(AW0)) bus ();
  wu_sched_if #(.ADDR_W(AW1)) bus2 ();

  wu_sched #(.ADDR_W(AW0), .SUB_LAT(LAT0)) dut  (.clk(clk), .rst(rst), .bus(bus));
  wu_sched #(.ADDR_W(AW1), .SUB_LAT(LAT1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input kind_t k, input int c, input int a, input int limit);
    ev_t e;
    if (c >= limit) return;
    e.dut = d; e.kind = k; e.cyc = c; e.addr = a;
    expQ.push_back(e);
  endtask

  // Timeline of a job accepted in cycle c0; pause covers relative cycles pLo..pHi; events at or after c0+cut are dropped.
  task automatic expect_job(input int d, input int c0, input int n, input int pLo, input int pHi, input int cut);
    int lat, lim, t, a, last;
    lat = (d == 0) ? LAT0 : LAT1;
    lim = c0 + cut;
    t = c0 + 1; a = 0; last = 0;
    if (n == 0) begin
      push(d, K_DONE, c0 + 1, 0, lim);
      return;
    end
    while (a < n) begin
      if (!(t - c0 >= pLo && t - c0 <= pHi)) begin
        push(d, K_RD,  t,           a, lim);
        push(d, K_SUB, t + 1,       0, lim);
        push(d, K_WR,  t + 1 + lat, a, lim);
        last = t;
        a++;
      end
      t++;
    end
    push(d, K_DONE, last + 2 + lat, 0, lim);
  endtask

  task automatic observe(input int d, input kind_t k, input int a, input string name);
    int idx;
    idx = -1;
    foreach (expQ[i]) if (idx < 0 && expQ[i].dut == d && expQ[i].kind == k) idx = i;
    check({name, " expected"}, int'(idx >= 0), 1);
    if (idx >= 0) begin
      check({name, " cycle"}, cyc, expQ[idx].cyc);
      check({name, " addr"}, a, expQ[idx].addr);
      expQ.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_en)   observe(0, K_RD,  int'(bus.rd_addr), "dut0 rd");
    if (bus.sub_en)  observe(0, K_SUB, 0, "dut0 sub");
    if (bus.wr_en)   observe(0, K_WR,  int'(bus.wr_addr), "dut0 wr");
    if (bus.done) begin
      observe(0, K_DONE, 0, "dut0 done");
      lastDone[0] = cyc;
    end
    if (bus2.rd_en)  observe(1, K_RD,  int'(bus2.rd_addr), "dut2 rd");
    if (bus2.sub_en) observe(1, K_SUB, 0, "dut2 sub");
    if (bus2.wr_en)  observe(1, K_WR,  int'(bus2.wr_addr), "dut2 wr");
    if (bus2.done) begin
      observe(1, K_DONE, 0, "dut2 done");
      lastDone[1] = cyc;
    end
  end

  task automatic drive(input int d, input logic s, input int n);
    if (d == 0) begin
      bus.start = s;  bus.num_rows = (AW0+1)'(n);
    end else begin
      bus2.start = s; bus2.num_rows = (AW1+1)'(n);
    end
  endtask

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus.busy : bus2.busy;
  endfunction

  // Accepts a job on the next edge, then drives the pause window; returns in cycle c0+pHi+1 (at least c0+1).
  task automatic start_job(input int d, input int n, input int pLo, input int pHi, input int cut, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    drive(d, 1'b1, n);
    expect_job(d, c0, n, pLo, pHi, cut);
    for (int k = 1; k <= pHi + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) drive(d, 1'b0, n + 3);
      bus.pause = (d == 0) && k >= pLo && k <= pHi;
    end
  endtask

  task automatic wait_idle(input int d, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (busy_of(d) == 1'b0) break;
      @(posedge clk); #1;
    end
    check({name, " idle"}, int'(busy_of(d)), 0);
  endtask

  task automatic check_perf(input int d, input int exp, input string name);
    int act, want;
    act  = (d == 0) ? int'(bus.perf_cycles) : int'(bus2.perf_cycles);
    want = exp;
`ifndef WU_SCHED_PERF_EN
    want = 0;
`endif
    check({name, " perf"}, act, want);
  endtask

  task automatic check_dut0_quiet(input string name);
    check({name, " rd_en"},   int'(bus.rd_en),   0);
    check({name, " rd_addr"}, int'(bus.rd_addr), 0);
    check({name, " sub_en"},  int'(bus.sub_en),  0);
    check({name, " wr_en"},   int'(bus.wr_en),   0);
    check({name, " wr_addr"}, int'(bus.wr_addr), 0);
    check({name, " busy"},    int'(bus.busy),    0);
    check({name, " done"},    int'(bus.done),    0);
    check({name, " perf"},    int'(bus.perf_cycles), 0);
  endtask

  initial begin
    int c0;
    lastDone[0] = -1;
    lastDone[1] = -1;
    bus.start = 1'b0;  bus.num_rows = '0;  bus.pause = 1'b0;
    bus2.start = 1'b0; bus2.num_rows = '0; bus2.pause = 1'b0;

    // Outputs held at zero under reset.
    repeat (2) @(negedge clk);
    check_dut0_quiet("reset");
    check("reset dut2 outputs",
          int'({bus2.rd_en, bus2.sub_en, bus2.wr_en, bus2.busy, bus2.done,
                |bus2.rd_addr, |bus2.wr_addr, |bus2.perf_cycles}), 0);

    // N=4, no pause, start on the first edge after release: done 17 cycles after accept.
    @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    drive(0, 1'b1, 4);
    expect_job(0, c0, 4, 1, 0, 1000);
    @(posedge clk); #1;
    drive(0, 1'b0, 9);
    check("first edge accept busy", int'(bus.busy), 1);
    wait_idle(0, 40, "N4");
    check("N4 done latency", lastDone[0] - c0, 17);
    check_perf(0, 17, "N4");

    // N=3 with pause in cycles 2-3: done 18 cycles after accept.
    start_job(0, 3, 2, 3, 1000, c0);
    wait_idle(0, 40, "N3 pause");
    check("N3 pause done latency", lastDone[0] - c0, 18);
    check_perf(0, 18, "N3 pause");

    // Empty job: busy and done in cycle 1 only.
    start_job(0, 0, 1, 0, 1000, c0);
    check("empty busy cycle1", int'(bus.busy), 1);
    @(posedge clk); #1;
    check("empty busy cycle2", int'(bus.busy), 0);
    check("empty done latency", lastDone[0] - c0, 1);
    check_perf(0, 1, "empty");

    // ADDR_W=2, full 4-row job; extra start while busy and a start in DONE are both ignored.
    start_job(1, 4, 1, 0, 1000, c0);
    @(posedge clk); #1;
    drive(1, 1'b1, 2);
    @(posedge clk); #1;
    drive(1, 1'b0, 2);
    for (int k = 0; k < 30 && !bus2.done; k++) begin
      @(posedge clk); #1;
    end
    drive(1, 1'b1, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1);
    check("AW2 start in DONE ignored", int'(bus2.busy), 0);
    check("AW2 done latency", lastDone[1] - c0, 9);
    check_perf(1, 9, "AW2");
    repeat (3) @(posedge clk);
    #1;
    check("AW2 still idle", int'(bus2.busy), 0);

    // Reset in cycle 6 of an N=8 job: immediate quiet outputs, nothing emitted afterwards.
    start_job(0, 8, 1, 0, 6, c0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_dut0_quiet("mid-job reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post-reset quiet busy", int'(bus.busy), 0);

    // Fresh N=2 job after the abort: done 15 cycles after accept.
    start_job(0, 2, 1, 0, 1000, c0);
    wait_idle(0, 40, "N2 after reset");
    check("N2 done latency", lastDone[0] - c0, 15);
    check_perf(0, 15, "N2 after reset");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
